// File: rtl/axi_mem_arbiter_if.sv
// AXI-style read and write channel bundles shared by the arbiter and its peers.
//   axi_read_if  : AR channel (arvalid/arready/araddr/arlen/arsize/arburst)
//                  and R channel (rvalid/rready/rdata/rlast)
//   axi_write_if : AW channel (awvalid/awready/awaddr/awlen/awsize/awburst),
//                  W channel (wvalid/wready/wdata/wstrb/wlast) and
//                  B channel (bvalid/bready/bresp)
// The master modport issues requests; the slave modport answers them.

interface axi_read_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rlast
    );
endinterface

interface axi_write_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Arbitrates two read requesters (icache, dcache refill) onto one memory read
// port and forwards the single dcache write-back requester to the memory write
// port. Read and write paths run independently.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   icache_rd, dcache_rd : read requesters 0 and 1
//   dcache_wr            : write requester
//   mem_rd, mem_wr       : shared memory read / write ports
//   rd_err, wr_err       : sticky burst-length mismatch flags
//   busy                 : either path not idle

module axi_mem_arbiter #(
    parameter bit          RR_EN     = 1'b1,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    axi_read_if.slave   icache_rd,
    axi_read_if.slave   dcache_rd,
    axi_write_if.slave  dcache_wr,
    axi_read_if.master  mem_rd,
    axi_write_if.master mem_wr,
    output logic        rd_err,
    output logic        wr_err,
    output logic        busy
);

    localparam int unsigned BEAT_W = $clog2(BURST_MAX) + 1;
    localparam int unsigned LEN_W  = 9;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    r_state_e          r_state_q, r_state_d;
    logic              gnt_q, gnt_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              rd_err_q, rd_err_d;

    w_state_e          w_state_q, w_state_d;
    logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
    logic [7:0]        awlen_q, awlen_d;
    logic              wr_err_q, wr_err_d;

    logic              busy_q, busy_d;

    // Read path: grant, address forwarding and beat routing to the granted requester.
    always_comb begin
        r_state_d = r_state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        rd_beat_d = rd_beat_q;
        arlen_d   = arlen_q;
        rd_err_d  = rd_err_q;

        mem_rd.arvalid    = 1'b0;
        mem_rd.araddr     = '0;
        mem_rd.arlen      = '0;
        mem_rd.arsize     = '0;
        mem_rd.arburst    = '0;
        mem_rd.rready     = 1'b0;
        icache_rd.arready = 1'b0;
        icache_rd.rvalid  = 1'b0;
        icache_rd.rdata   = '0;
        icache_rd.rlast   = 1'b0;
        dcache_rd.arready = 1'b0;
        dcache_rd.rvalid  = 1'b0;
        dcache_rd.rdata   = '0;
        dcache_rd.rlast   = 1'b0;

        unique case (r_state_q)
            R_IDLE: begin
                if (icache_rd.arvalid && dcache_rd.arvalid) begin
                    gnt_d = RR_EN ? rr_ptr_q : 1'b0;
                end else if (icache_rd.arvalid) begin
                    gnt_d = 1'b0;
                end else if (dcache_rd.arvalid) begin
                    gnt_d = 1'b1;
                end
                if (icache_rd.arvalid || dcache_rd.arvalid) begin
                    r_state_d = R_ADDR;
                end
            end

            R_ADDR: begin
                mem_rd.arvalid = 1'b1;
                if (gnt_q) begin
                    mem_rd.araddr     = dcache_rd.araddr;
                    mem_rd.arlen      = dcache_rd.arlen;
                    mem_rd.arsize     = dcache_rd.arsize;
                    mem_rd.arburst    = dcache_rd.arburst;
                    dcache_rd.arready = mem_rd.arready;
                    arlen_d           = dcache_rd.arlen;
                end else begin
                    mem_rd.araddr     = icache_rd.araddr;
                    mem_rd.arlen      = icache_rd.arlen;
                    mem_rd.arsize     = icache_rd.arsize;
                    mem_rd.arburst    = icache_rd.arburst;
                    icache_rd.arready = mem_rd.arready;
                    arlen_d           = icache_rd.arlen;
                end
                // arlen_d only sticks when the address handshake completes.
                if (mem_rd.arready) begin
                    rd_beat_d = '0;
                    r_state_d = R_DATA;
                end else begin
                    arlen_d = arlen_q;
                end
            end

            R_DATA: begin
                if (gnt_q) begin
                    mem_rd.rready    = dcache_rd.rready;
                    dcache_rd.rvalid = mem_rd.rvalid;
                    dcache_rd.rdata  = mem_rd.rdata;
                    dcache_rd.rlast  = mem_rd.rlast;
                end else begin
                    mem_rd.rready    = icache_rd.rready;
                    icache_rd.rvalid = mem_rd.rvalid;
                    icache_rd.rdata  = mem_rd.rdata;
                    icache_rd.rlast  = mem_rd.rlast;
                end
                if (mem_rd.rvalid && (gnt_q ? dcache_rd.rready : icache_rd.rready)) begin
                    rd_beat_d = rd_beat_q + BEAT_W'(1);
                    if (mem_rd.rlast) begin
                        // Length mismatch is flagged but the burst still ends here.
                        if (LEN_W'(rd_beat_q) + LEN_W'(1) != LEN_W'(arlen_q) + LEN_W'(1)) begin
                            rd_err_d = 1'b1;
                        end
                        rr_ptr_d  = ~gnt_q;
                        r_state_d = R_IDLE;
                    end
                end
            end

            default: r_state_d = R_IDLE;
        endcase
    end

    // Write path: aw/w/b pass-through sequenced by the write FSM.
    always_comb begin
        w_state_d = w_state_q;
        wr_beat_d = wr_beat_q;
        awlen_d   = awlen_q;
        wr_err_d  = wr_err_q;

        mem_wr.awvalid    = 1'b0;
        mem_wr.awaddr     = dcache_wr.awaddr;
        mem_wr.awlen      = dcache_wr.awlen;
        mem_wr.awsize     = dcache_wr.awsize;
        mem_wr.awburst    = dcache_wr.awburst;
        mem_wr.wvalid     = 1'b0;
        mem_wr.wdata      = dcache_wr.wdata;
        mem_wr.wstrb      = dcache_wr.wstrb;
        mem_wr.wlast      = dcache_wr.wlast;
        mem_wr.bready     = 1'b0;
        dcache_wr.awready = 1'b0;
        dcache_wr.wready  = 1'b0;
        dcache_wr.bvalid  = 1'b0;
        dcache_wr.bresp   = mem_wr.bresp;

        unique case (w_state_q)
            W_IDLE: begin
                // Pass-through is combinational, so it is gated directly by reset.
                mem_wr.awvalid    = dcache_wr.awvalid & ~rst;
                dcache_wr.awready = mem_wr.awready & ~rst;
                if (dcache_wr.awvalid && mem_wr.awready) begin
                    awlen_d   = dcache_wr.awlen;
                    wr_beat_d = '0;
                    w_state_d = W_DATA;
                end
            end

            W_DATA: begin
                mem_wr.wvalid    = dcache_wr.wvalid;
                dcache_wr.wready = mem_wr.wready;
                if (dcache_wr.wvalid && mem_wr.wready) begin
                    wr_beat_d = wr_beat_q + BEAT_W'(1);
                    if (dcache_wr.wlast) begin
                        if (LEN_W'(wr_beat_q) + LEN_W'(1) != LEN_W'(awlen_q) + LEN_W'(1)) begin
                            wr_err_d = 1'b1;
                        end
                        w_state_d = W_RESP;
                    end
                end
            end

            W_RESP: begin
                dcache_wr.bvalid = mem_wr.bvalid;
                mem_wr.bready    = dcache_wr.bready;
                if (mem_wr.bvalid && dcache_wr.bready) begin
                    w_state_d = W_IDLE;
                end
            end

            default: w_state_d = W_IDLE;
        endcase
    end

    // busy tracks the next state so the flop matches the current state exactly.
    always_comb begin
        busy_d = (r_state_d != R_IDLE) || (w_state_d != W_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            gnt_q     <= 1'b0;
            rr_ptr_q  <= 1'b0;
            rd_beat_q <= '0;
            arlen_q   <= '0;
            rd_err_q  <= 1'b0;
            w_state_q <= W_IDLE;
            wr_beat_q <= '0;
            awlen_q   <= '0;
            wr_err_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_beat_q <= rd_beat_d;
            arlen_q   <= arlen_d;
            rd_err_q  <= rd_err_d;
            w_state_q <= w_state_d;
            wr_beat_q <= wr_beat_d;
            awlen_q   <= awlen_d;
            wr_err_q  <= wr_err_d;
            busy_q    <= busy_d;
        end
    end

    assign rd_err = rd_err_q;
    assign wr_err = wr_err_q;
    assign busy   = busy_q;

endmodule
